// File: rtl/ifu_fetch_queue_pkg.sv
// Shared definitions for the queued instruction fetch unit.
package ifu_fetch_queue_pkg;

    localparam int RegWidth   = 64;   // PC width
    localparam int INSTWide   = 32;   // instruction width
    localparam int MemAddrBus = 32;   // imem address bus width
    localparam int MemDataBus = 64;   // imem data bus width

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Fetch FSM: IDLE waits for a credit, REQ drives the AR channel,
    // WAIT accepts the single R beat belonging to that request.
    typedef enum logic [1:0] {
        IFQ_IDLE = 2'd0,
        IFQ_REQ  = 2'd1,
        IFQ_WAIT = 2'd2
    } ifq_state_e;

endpackage

// File: rtl/ifu_fetch_queue_fifo.sv
// Synchronous FIFO holding fetched {pc, inst, fault} entries.
// Flush has priority over push and pop; pop on empty and push on full are ignored.
module ifq_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign do_push = push_i && (count_q != (AW+1)'(DEPTH)) && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch unit: AXI-lite read master toward imem feeding a fetch
// queue ahead of IDU, with jump/interrupt redirect, flush and response squash.
module ifu_fetch_queue
    import ifu_fetch_queue_pkg::*;
#(
    parameter int          XLEN     = RegWidth,
    parameter int          ADDR_W   = MemAddrBus,
    parameter int          DATA_W   = MemDataBus,
    parameter int          INST_W   = INSTWide,
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              isIntrPC,
    input  logic [XLEN-1:0]   IntrPC,
    input  logic              is_jump,
    input  logic [XLEN-1:0]   JumpPc,
    output logic              ARVALID,
    output logic [ADDR_W-1:0] ARADDR,
    input  logic              ARREADY,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   pc_o,
    output logic              fault_o,
    output logic              ifu_valid,
    input  logic              idu_ready
);
    // Handshake rule used on every channel here: a transfer happens on a
    // rising clk edge where valid and ready are both high; once ARVALID is
    // raised, it and ARADDR hold until ARREADY, and RREADY is high for the
    // whole WAIT state so RVALID is never stalled.

    localparam int EW    = XLEN + INST_W + 1;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OFF_W = $clog2(DATA_W / 8);

    ifq_state_e        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              drop_q, drop_d;

    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic [INST_W-1:0] lane_inst;
    logic              fifo_push, fifo_pop, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [EW-1:0]     fifo_head;

    assign redirect    = isIntrPC | is_jump;
    assign redirect_pc = isIntrPC ? IntrPC : JumpPc;

    // Pick the instruction lane addressed by the request PC inside the data beat.
    generate
        if (OFF_W > 2) begin : g_lane_mux
            logic [OFF_W-3:0] lane_idx;
            assign lane_idx  = req_pc_q[OFF_W-1:2];
            assign lane_inst = RDATA[lane_idx*INST_W +: INST_W];
        end else begin : g_lane_single
            assign lane_inst = RDATA[INST_W-1:0];
        end
    endgenerate

    // ARADDR comes from req_pc, latched when leaving IDLE, so it cannot move
    // while a request is held even if fetch_pc is redirected meanwhile.
    assign ARADDR = req_pc_q[ADDR_W-1:0];

    // Next-state logic: issue/accept sequencing, PC advance, drop tracking.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        fifo_push  = 1'b0;
        case (state_q)
            IFQ_IDLE: begin
                // In IDLE nothing is outstanding, so the credit check is count < DEPTH.
                if (!redirect && (fifo_count < CW'(DEPTH))) begin
                    state_d  = IFQ_REQ;
                    req_pc_d = fetch_pc_q;
                end
            end
            IFQ_REQ: begin
                ARVALID = 1'b1;
                // A redirect cannot withdraw the address; mark its response stale.
                if (redirect) drop_d = 1'b1;
                if (ARREADY) begin
                    state_d = IFQ_WAIT;
                    if (!drop_q && !redirect) fetch_pc_d = fetch_pc_q + XLEN'(4);
                end
            end
            IFQ_WAIT: begin
                RREADY = 1'b1;
                if (redirect) drop_d = 1'b1;
                if (RVALID) begin
                    state_d   = IFQ_IDLE;
                    drop_d    = 1'b0;
                    fifo_push = !drop_q && !redirect;
                end
            end
            default: state_d = IFQ_IDLE;
        endcase
        if (redirect) fetch_pc_d = redirect_pc;
    end

    // FSM and fetch-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IFQ_IDLE;
            fetch_pc_q <= RESET_PC[XLEN-1:0];
            req_pc_q   <= RESET_PC[XLEN-1:0];
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
        end
    end

    // A redirect flushes the queue and voids any pop in the same cycle.
    assign fifo_pop = ifu_valid && idu_ready && !redirect;

    ifq_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .data_i  ({req_pc_q, lane_inst, (RRESP != RESP_OKAY)}),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign ifu_valid = !fifo_empty;
    assign {pc_o, inst_o, fault_o} = fifo_head;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: a reactive imem model, directed scenarios with
// literal expectations, then randomized traffic checked every cycle against a
// transaction-level model of the fetch stream.
module tb_ifu_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT signals
  logic        isIntrPC, is_jump, idu_ready;
  logic [63:0] IntrPC, JumpPc;
  logic        ARVALID, RREADY, fault_o, ifu_valid;
  logic [31:0] ARADDR, inst_o;
  logic [63:0] pc_o;
  logic        ARREADY = 1'b0;
  logic        RVALID  = 1'b0;
  logic [63:0] RDATA   = '0;
  logic [1:0]  RRESP   = 2'b00;

  ifu_fetch_queue #(
    .XLEN(64), .ADDR_W(32), .DATA_W(64), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .isIntrPC(isIntrPC), .IntrPC(IntrPC), .is_jump(is_jump), .JumpPc(JumpPc),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .inst_o(inst_o), .pc_o(pc_o), .fault_o(fault_o),
    .ifu_valid(ifu_valid), .idu_ready(idu_ready)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model state: expected queue of {pc, inst, fault}
  logic [96:0] exp_q[$];
  logic [63:0] m_pc, ar_pc, rd_pc;
  logic        ar_pend, ar_live, rd_live, rd_out, mon_en;
  logic [31:0] prev_araddr;

  // handoff from the monitor to the imem driver
  logic        ar_hs_seen = 1'b0, r_hs_seen = 1'b0, rst_seen = 1'b0;
  logic [31:0] hs_addr = '0;

  // imem knobs
  int          ar_mode = 0;          // 0: always ready, 1: random, 2: never ready
  int          r_dly_min = 0, r_dly_max = 0;
  logic        data_rand = 1'b0, resp_rand = 1'b0, fault_next = 1'b0;
  logic [31:0] fault_addr = '0;

  function automatic logic [63:0] pattern(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:3], 3'b000};
    return {32'hB000_0000 ^ (al | 32'h4), 32'hA000_0000 ^ al};
  endfunction

  // monitor + model: compare this cycle's outputs, then apply the coming edge
  always @(negedge clk) begin : mon
    logic        redir;
    logic [31:0] ln;
    ar_hs_seen = 1'b0;
    r_hs_seen  = 1'b0;
    rst_seen   = rst;
    if (rst) begin
      exp_q.delete();
      m_pc    = RESET_PC;
      ar_pend = 1'b0;
      ar_live = 1'b0;
      rd_live = 1'b0;
      rd_out  = 1'b0;
    end else if (mon_en) begin
      redir = isIntrPC | is_jump;
      chk("ifu_valid", ifu_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("head_entry", {pc_o, inst_o, fault_o}, exp_q[0]);
      chk("rready", RREADY, rd_out);
      if (exp_q.size() == DEPTH) chk("no_ar_when_full", ARVALID, 1'b0);
      if (ar_pend) begin
        chk("arvalid_held", ARVALID, 1'b1);
        chk("araddr_stable", ARADDR, prev_araddr);
      end else if (ARVALID) begin
        chk("ar_credit", (exp_q.size() < DEPTH) && !rd_out, 1'b1);
        chk("araddr", ARADDR, m_pc[31:0]);
        ar_pc   = m_pc;
        ar_live = 1'b1;
      end
      if (ifu_valid && idu_ready && !redir && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (RVALID && RREADY) begin
        r_hs_seen = 1'b1;
        ln = rd_pc[2] ? RDATA[63:32] : RDATA[31:0];
        if (rd_live && !redir) exp_q.push_back({rd_pc, ln, RRESP != 2'b00});
        rd_out = 1'b0;
      end
      if (ARVALID && ARREADY) begin
        ar_hs_seen = 1'b1;
        hs_addr    = ARADDR;
        rd_out     = 1'b1;
        rd_pc      = ar_pc;
        rd_live    = ar_live && !redir;
        if (rd_live) m_pc = m_pc + 64'd4;
      end
      ar_pend     = ARVALID && !ARREADY;
      prev_araddr = ARADDR;
      if (redir) begin
        exp_q.delete();
        m_pc    = isIntrPC ? IntrPC : JumpPc;
        ar_live = 1'b0;
        rd_live = 1'b0;
      end
    end
  end

  // imem driver: one outstanding read, configurable AR/R latency
  initial begin : imem
    logic        d_out;
    int          d_wait;
    logic [31:0] d_addr;
    d_out = 1'b0; d_wait = 0; d_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_seen) begin
        d_out  = 1'b0;
        RVALID = 1'b0;
      end else begin
        if (r_hs_seen) begin
          RVALID = 1'b0;
          d_out  = 1'b0;
        end
        if (ar_hs_seen) begin
          d_out  = 1'b1;
          d_addr = hs_addr;
          d_wait = $urandom_range(r_dly_min, r_dly_max);
        end
        if (d_out && !RVALID) begin
          if (d_wait == 0) begin
            RVALID = 1'b1;
            RDATA  = data_rand ? {$urandom, $urandom} : pattern(d_addr);
            RRESP  = (resp_rand && $urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
            if (fault_next) begin
              RRESP      = 2'b10;
              fault_addr = d_addr;
              fault_next = 1'b0;
            end
          end else begin
            d_wait--;
          end
        end
      end
      ARREADY = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return ARVALID;
      1:       return ifu_valid;
      2:       return RREADY;
      3:       return ifu_valid && fault_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input string name, input int sel);
    int n = 0;
    while (!cond(sel) && n < 200) begin
      tick();
      n++;
    end
    chk(name, cond(sel), 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, ARVALID, 1'b0);
    chk({tag, "_rready"}, RREADY, 1'b0);
    chk({tag, "_ifu_valid"}, ifu_valid, 1'b0);
    chk({tag, "_inst"}, inst_o, 32'h0);
    chk({tag, "_pc"}, pc_o, 64'h0);
    chk({tag, "_fault"}, fault_o, 1'b0);
  endtask

  // stimulus
  initial begin : main
    logic [31:0] held;
    rst = 1'b1; mon_en = 1'b0; idu_ready = 1'b0;
    isIntrPC = 1'b0; is_jump = 1'b0; IntrPC = '0; JumpPc = '0;
    repeat (3) tick();
    rst = 1'b0; mon_en = 1'b1;
    chk_reset_outputs("reset");

    // 1: zero-wait fetch stream from RESET_PC, lane follows pc[2]
    idu_ready = 1'b1;
    wait_cond("t1_ar_timeout", 0);
    chk("t1_araddr0", ARADDR, 32'h8000_0000);
    tick();
    chk("t1_not_yet_valid", ifu_valid, 1'b0);
    tick();
    chk("t1_latency2", ifu_valid, 1'b1);
    chk("t1_pc0", pc_o, 64'h8000_0000);
    chk("t1_inst0_lo", inst_o, 32'h2000_0000);
    chk("t1_fault0", fault_o, 1'b0);
    tick();
    wait_cond("t1_valid1_timeout", 1);
    chk("t1_pc1", pc_o, 64'h8000_0004);
    chk("t1_inst1_hi", inst_o, 32'h3000_0004);

    // 2: IDU stall fills exactly DEPTH entries and stops issue
    idu_ready = 1'b0;
    repeat (20) tick();
    chk("t2_model_full", exp_q.size(), DEPTH);
    chk("t2_valid", ifu_valid, 1'b1);
    chk("t2_no_ar", ARVALID, 1'b0);
    idu_ready = 1'b1;
    repeat (20) tick();

    // 3: ARREADY held low, then slow RVALID
    ar_mode = 2;
    tick(); tick();
    wait_cond("t3_ar_timeout", 0);
    held = ARADDR;
    repeat (5) begin
      tick();
      chk("t3_arvalid_hold", ARVALID, 1'b1);
      chk("t3_araddr_hold", ARADDR, held);
    end
    r_dly_min = 3; r_dly_max = 3;
    ar_mode = 0;
    wait_cond("t3_wait_timeout", 2);
    repeat (3) begin
      chk("t3_rready_wait", RREADY, 1'b1);
      chk("t3_rvalid_late", RVALID, 1'b0);
      tick();
    end
    wait_cond("t3_valid_timeout", 1);
    chk("t3_entry_pc", pc_o[31:0], held);

    // 4: jump while waiting for data
    r_dly_min = 5; r_dly_max = 5;
    wait_cond("t4_wait_timeout", 2);
    is_jump = 1'b1; JumpPc = 64'h8000_0100;
    tick();
    is_jump = 1'b0;
    r_dly_min = 0; r_dly_max = 0;
    wait_cond("t4_valid_timeout", 1);
    chk("t4_pc", pc_o, 64'h8000_0100);
    chk("t4_inst", inst_o, 32'h2000_0100);

    // 5a: interrupt beats jump
    isIntrPC = 1'b1; IntrPC = 64'h8000_0200;
    is_jump = 1'b1;  JumpPc = 64'h8000_0300;
    tick();
    isIntrPC = 1'b0; is_jump = 1'b0;
    wait_cond("t5_valid_timeout", 1);
    chk("t5_intr_pc", pc_o, 64'h8000_0200);
    chk("t5_intr_inst", inst_o, 32'h2000_0200);

    // 5b: redirect while the address is still unaccepted
    ar_mode = 2;
    tick(); tick();
    wait_cond("t5b_ar_timeout", 0);
    is_jump = 1'b1; JumpPc = 64'h8000_0400;
    tick();
    is_jump = 1'b0;
    ar_mode = 0;
    wait_cond("t5b_valid_timeout", 1);
    chk("t5b_pc", pc_o, 64'h8000_0400);
    chk("t5b_inst", inst_o, 32'h2000_0400);

    // 6a: one faulting beat
    fault_next = 1'b1;
    wait_cond("t6_fault_timeout", 3);
    chk("t6_fault_pc", pc_o[31:0], fault_addr);
    tick();
    wait_cond("t6_next_timeout", 1);
    chk("t6_next_no_fault", fault_o, 1'b0);

    // 6b: reset in the middle of WAIT
    r_dly_min = 5; r_dly_max = 5;
    wait_cond("t6b_wait_timeout", 2);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    r_dly_min = 0; r_dly_max = 0;
    wait_cond("t6b_ar_timeout", 0);
    chk("t6b_refetch", ARADDR, 32'h8000_0000);

    // randomized traffic
    ar_mode = 1; data_rand = 1'b1; resp_rand = 1'b1;
    r_dly_min = 0; r_dly_max = 3;
    repeat (3000) begin
      tick();
      idu_ready = ($urandom_range(0, 3) != 0);
      is_jump   = ($urandom_range(0, 39) == 0);
      isIntrPC  = ($urandom_range(0, 79) == 0);
      JumpPc    = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                              : ({$urandom, $urandom} & ~64'h3);
      IntrPC    = {$urandom, $urandom} & ~64'h3;
      rst       = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0; is_jump = 1'b0; isIntrPC = 1'b0; idu_ready = 1'b1;
    repeat (20) tick();
    chk("progress", n_pop > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
